// File: rtl/gtx_cpll_seq.sv
// Power-up/reset sequencer for one GTX CPLL: rail, PLL reset, lock wait, datapath reset, ready.
// Async lock/resetdone inputs pass through 2-FF synchronizers; all outputs are registered from next state.
module gtx_cpll_seq #(
  parameter int RAIL_CYCLES   = 1024,
  parameter int PLLRST_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int GTRST_CYCLES  = 16,
  parameter int CW            = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       cplllock,
  input  logic       resetdone,
  output logic       cpllpd,
  output logic       cpllreset,
  output logic       gt_reset,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_RAIL      = 3'd0,
    S_PLLRST    = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_GTRST     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [CW-1:0] RAIL_LAST   = CW'(RAIL_CYCLES - 1);
  localparam logic [CW-1:0] PLLRST_LAST = CW'(PLLRST_CYCLES - 1);
  localparam logic [CW-1:0] GTRST_LAST  = CW'(GTRST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          lock_meta;
  logic          lock_s;
  logic          done_meta;
  logic          done_s;
  logic          bump;
  logic          lock_lost;
  logic          enter;

  assign state_o = state;

  // Lock only matters once the PLL has been released from reset and has locked once.
  assign lock_lost = !lock_s &&
                     (state == S_GTRST || state == S_WAIT_DONE || state == S_DONE);

  always_comb begin
    nxt  = state;
    bump = 1'b0;
    if (restart) begin
      nxt = S_RAIL;
    end else if (lock_lost) begin
      nxt  = S_PLLRST;
      bump = 1'b1;
    end else begin
      case (state)
        S_RAIL:      if (cnt == RAIL_LAST) nxt = S_PLLRST;
        S_PLLRST:    if (cnt == PLLRST_LAST) nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) begin
            nxt = S_GTRST;
          end else if (cnt == TMO_LAST) begin
            nxt  = S_RAIL;
            bump = 1'b1;
          end
        end
        S_GTRST:     if (cnt == GTRST_LAST) nxt = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (done_s) begin
            nxt = S_DONE;
          end else if (cnt == TMO_LAST) begin
            nxt  = S_RAIL;
            bump = 1'b1;
          end
        end
        S_DONE:      nxt = S_DONE;
        default:     nxt = S_RAIL;
      endcase
    end
  end

  // A restart while already in RAIL still re-enters it, so the rail interval starts over.
  assign enter = restart || (nxt != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      done_meta   <= 1'b0;
      done_s      <= 1'b0;
      state       <= S_RAIL;
      cnt         <= '0;
      retry_count <= 4'd0;
      cpllpd      <= 1'b1;
      cpllreset   <= 1'b1;
      gt_reset    <= 1'b1;
      ready       <= 1'b0;
    end else begin
      lock_meta <= cplllock;
      lock_s    <= lock_meta;
      done_meta <= resetdone;
      done_s    <= done_meta;
      state     <= nxt;
      cnt       <= enter ? '0 : cnt + CW'(1);
      if (bump && retry_count != 4'd15) retry_count <= retry_count + 4'd1;
      case (nxt)
        S_PLLRST: begin
          cpllpd <= 1'b0; cpllreset <= 1'b1; gt_reset <= 1'b1; ready <= 1'b0;
        end
        S_WAIT_LOCK, S_GTRST: begin
          cpllpd <= 1'b0; cpllreset <= 1'b0; gt_reset <= 1'b1; ready <= 1'b0;
        end
        S_WAIT_DONE: begin
          cpllpd <= 1'b0; cpllreset <= 1'b0; gt_reset <= 1'b0; ready <= 1'b0;
        end
        S_DONE: begin
          cpllpd <= 1'b0; cpllreset <= 1'b0; gt_reset <= 1'b0; ready <= 1'b1;
        end
        default: begin
          cpllpd <= 1'b1; cpllreset <= 1'b1; gt_reset <= 1'b1; ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtx_cpll_seq.sv
// Directed bench for gtx_cpll_seq with short rail/reset/timeout intervals.
module tb_gtx_cpll_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic       cplllock = 1'b0;
  logic       resetdone = 1'b0;
  logic       cpllpd;
  logic       cpllreset;
  logic       gt_reset;
  logic       ready;
  logic [3:0] retry_count;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  gtx_cpll_seq #(
    .RAIL_CYCLES(8), .PLLRST_CYCLES(4), .LOCK_TIMEOUT(32), .GTRST_CYCLES(4), .CW(17)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .cplllock(cplllock), .resetdone(resetdone),
    .cpllpd(cpllpd), .cpllreset(cpllreset), .gt_reset(gt_reset), .ready(ready),
    .retry_count(retry_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, restart, lock, done;
    int         n;
    logic [2:0] st;
    logic [3:0] rc;
    logic       rdy, gr, pr, pd;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic r, input logic rs, input logic l, input logic d, input int n,
                              input logic [2:0] st, input logic [3:0] rc,
                              input logic rdy, input logic gr, input logic pr, input logic pd);
    vec_t v;
    v.rst = r; v.restart = rs; v.lock = l; v.done = d; v.n = n;
    v.st = st; v.rc = rc; v.rdy = rdy; v.gr = gr; v.pr = pr; v.pd = pd;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k = 0;
    while (state_o !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {13'd0, state_o}, {13'd0, s});
  endtask

  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; cplllock = 1'b0; resetdone = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pd_n, pr_n, fall_pr, fall_gt, n, tmo;
    logic seen_rdy;
    logic [2:0] prev;

    // Output bundle order: {state, retry, ready, gt_reset, cpllreset, cpllpd}
    vt[0]  = mk(1, 0, 0, 0, 1, 3'd0, 4'd0, 0, 1, 1, 1);
    vt[1]  = mk(0, 0, 1, 0, 7, 3'd0, 4'd0, 0, 1, 1, 1);
    vt[2]  = mk(0, 0, 1, 0, 1, 3'd1, 4'd0, 0, 1, 1, 0);
    vt[3]  = mk(0, 0, 1, 0, 3, 3'd1, 4'd0, 0, 1, 1, 0);
    vt[4]  = mk(0, 0, 1, 0, 1, 3'd2, 4'd0, 0, 1, 0, 0);
    vt[5]  = mk(0, 0, 1, 0, 1, 3'd3, 4'd0, 0, 1, 0, 0);
    vt[6]  = mk(0, 0, 1, 0, 3, 3'd3, 4'd0, 0, 1, 0, 0);
    vt[7]  = mk(0, 0, 1, 0, 1, 3'd4, 4'd0, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 1, 1, 2, 3'd4, 4'd0, 0, 0, 0, 0);
    vt[9]  = mk(0, 0, 1, 1, 1, 3'd5, 4'd0, 1, 0, 0, 0);
    vt[10] = mk(0, 1, 1, 1, 1, 3'd0, 4'd0, 0, 1, 1, 1);
    vt[11] = mk(0, 0, 1, 1, 7, 3'd0, 4'd0, 0, 1, 1, 1);
    vt[12] = mk(0, 0, 1, 1, 1, 3'd1, 4'd0, 0, 1, 1, 0);

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; restart = vt[i].restart; cplllock = vt[i].lock; resetdone = vt[i].done;
      repeat (vt[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {5'd0, state_o, retry_count, ready, gt_reset, cpllreset, cpllpd},
            {5'd0, vt[i].st, vt[i].rc, vt[i].rdy, vt[i].gr, vt[i].pr, vt[i].pd});
    end
    restart = 1'b0;

    // Nominal: lock 10 cycles after cpllreset falls, resetdone 5 cycles after gt_reset falls.
    do_reset();
    pd_n = 0; pr_n = 0; fall_pr = -1; fall_gt = -1; seen_rdy = 1'b0;
    for (int k = 0; k < 300 && !seen_rdy; k++) begin
      if (k > 0) @(negedge clk);
      if (cpllpd) pd_n++;
      else if (cpllreset) pr_n++;
      if (fall_pr < 0 && !cpllreset) fall_pr = k;
      if (fall_pr >= 0 && k == fall_pr + 10) cplllock = 1'b1;
      if (fall_gt < 0 && !gt_reset) fall_gt = k;
      if (fall_gt >= 0 && k == fall_gt + 5) resetdone = 1'b1;
      if (ready) seen_rdy = 1'b1;
    end
    check("nom_pd_cycles", 16'(pd_n), 16'd8);
    check("nom_pllrst_cycles", 16'(pr_n), 16'd4);
    check("nom_ready", {15'd0, seen_rdy}, 16'd1);
    check("nom_retry", {12'd0, retry_count}, 16'd0);

    // Lock timeout and retry saturation.
    do_reset();
    wait_state(3'd2, 40, "tmo_enter_wait_lock");
    n = 0;
    while (state_o == 3'd2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_wait_lock_len", 16'(n), 16'd32);
    check("tmo_state", {13'd0, state_o}, 16'd0);
    check("tmo_cpllpd", {15'd0, cpllpd}, 16'd1);
    check("tmo_retry1", {12'd0, retry_count}, 16'd1);
    tmo = 1;
    for (int k = 0; k < 3000 && tmo < 17; k++) begin
      prev = state_o;
      @(negedge clk);
      if (prev == 3'd2 && state_o == 3'd0) begin
        tmo++;
        if (tmo == 15) check("sat_retry15", {12'd0, retry_count}, 16'd15);
        if (tmo == 16) check("sat_retry16", {12'd0, retry_count}, 16'd15);
        if (tmo == 17) check("sat_retry17", {12'd0, retry_count}, 16'd15);
      end
    end
    check("sat_timeouts_seen", 16'(tmo), 16'd17);

    // Lock loss from DONE.
    do_reset();
    cplllock = 1'b1; resetdone = 1'b1;
    wait_state(3'd5, 40, "loss_reach_done");
    check("loss_ready_before", {15'd0, ready}, 16'd1);
    cplllock = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("loss_state_hold", {13'd0, state_o}, 16'd5);
    @(posedge clk);
    @(negedge clk);
    check("loss_state", {13'd0, state_o}, 16'd1);
    check("loss_outs", {12'd0, ready, gt_reset, cpllreset, cpllpd}, 16'b0110);
    check("loss_retry", {12'd0, retry_count}, 16'd1);

    // Restart on the exact timeout cycle wins and leaves retry_count alone.
    do_reset();
    wait_state(3'd2, 40, "rvt_enter_wait_lock");
    repeat (31) @(posedge clk);
    @(negedge clk);
    check("rvt_pre_state", {13'd0, state_o}, 16'd2);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    check("rvt_state", {13'd0, state_o}, 16'd0);
    check("rvt_retry", {12'd0, retry_count}, 16'd0);
    check("rvt_cpllpd", {15'd0, cpllpd}, 16'd1);

    // resetdone timeout, then asynchronous reset in the middle of the next WAIT_DONE.
    do_reset();
    cplllock = 1'b1;
    seen_rdy = 1'b0;
    wait_state(3'd4, 40, "rdt_enter_wait_done");
    n = 0;
    while (state_o == 3'd4 && n < 100) begin
      n++;
      if (ready) seen_rdy = 1'b1;
      @(negedge clk);
    end
    check("rdt_wait_done_len", 16'(n), 16'd32);
    check("rdt_state", {13'd0, state_o}, 16'd0);
    check("rdt_retry", {12'd0, retry_count}, 16'd1);
    wait_state(3'd4, 80, "ar_enter_wait_done");
    check("rdt_never_ready", {15'd0, seen_rdy | ready}, 16'd0);
    repeat (5) @(negedge clk);
    check("ar_pre_gt_reset", {15'd0, gt_reset}, 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_outs", {12'd0, ready, gt_reset, cpllreset, cpllpd}, 16'b0111);
    check("ar_retry", {12'd0, retry_count}, 16'd0);
    check("ar_state", {13'd0, state_o}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
